// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
// Also referenced by fifo_async formal properties and benches.
package fifo_rd_stream_pkg;

  localparam int FIFO_RD_LATENCY = 1;
  localparam int SKID_DEPTH      = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO-ordered skid buffer with 1-bit head/tail pointers.
// Occupancy is kept as a small FSM that also drives the valid output.
module skid_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            occ,
  output logic                  valid
);

  occ_state_e            state_reg;
  occ_state_e            state_next;
  logic                  head_reg;
  logic                  tail_reg;
  logic [DATA_WIDTH-1:0] mem_reg [SKID_DEPTH];
  logic                  push_ok;
  logic                  pop_ok;

  // Guards keep a misbehaving caller from corrupting pointers.
  assign push_ok = push && (state_reg != OCC_FULL);
  assign pop_ok  = pop  && (state_reg != OCC_EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= OCC_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCC_EMPTY: if (push_ok) state_next = OCC_ONE;
      OCC_ONE: begin
        if (push_ok && !pop_ok)      state_next = OCC_FULL;
        else if (!push_ok && pop_ok) state_next = OCC_EMPTY;
      end
      OCC_FULL:  if (pop_ok && !push_ok) state_next = OCC_ONE;
      default:   state_next = OCC_EMPTY;
    endcase
  end

  always_comb begin
    valid = (state_reg != OCC_EMPTY);
    occ   = state_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= 1'b0;
      tail_reg <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      head_reg <= head_reg ^ pop_ok;
      tail_reg <= tail_reg ^ push_ok;
      if (push_ok) mem_reg[tail_reg] <= wdata;
    end
  end

  // With push and pop at occ=1 the head advances onto the freshly written tail.
  assign rdata = mem_reg[head_reg];

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts the raw fifo_async read port (strobe, empty, 1-cycle data) into a
// valid/ready stream; reads are issued only when the skid buffer has room.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_fifo_rd,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_occ
);

  logic       inflight_reg;
  logic       pop;
  logic [1:0] occ;
  logic [2:0] pending;

  assign pop = o_valid & i_ready;

  // Words already owned after this cycle: buffered plus arriving minus leaving.
  assign pending = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};

  assign o_fifo_rd = !i_rst && !i_fifo_empty && (pending < 3'(SKID_DEPTH));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= o_fifo_rd;
    end
  end

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk  (i_clk),
    .rst  (i_rst),
    .push (inflight_reg),
    .pop  (pop),
    .wdata(i_fifo_rdata),
    .rdata(o_data),
    .occ  (occ),
    .valid(o_valid)
  );

  assign o_occ = occ;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_stream;

  logic       clk;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic [1:0] occ;

  logic [7:0] fifo_data [16];
  int         wr_count;
  int         rd_idx;
  logic       fifo_clear;
  logic       inflight_m;

  int n_pass;
  int n_total;

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_fifo_empty(fifo_empty),
    .i_fifo_rdata(fifo_rdata),
    .o_fifo_rd   (fifo_rd),
    .o_valid     (valid),
    .o_data      (data),
    .i_ready     (ready),
    .o_occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: data returned one cycle after the strobe; empty is registered state.
  always @(posedge clk) begin
    if (fifo_clear) begin
      rd_idx     <= 0;
      fifo_rdata <= 8'h00;
    end else if (fifo_rd) begin
      fifo_rdata <= fifo_data[rd_idx];
      rd_idx     <= rd_idx + 1;
    end
  end

  assign fifo_empty = (rd_idx >= wr_count);

  always @(posedge clk or posedge rst) begin
    if (rst) inflight_m <= 1'b0;
    else     inflight_m <= fifo_rd;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input logic [7:0] base);
    rst        = 1'b1;
    ready      = 1'b0;
    wr_count   = 0;
    fifo_clear = 1'b1;
    tick();
    tick();
    fifo_clear = 1'b0;
    for (int i = 0; i < 16; i++) fifo_data[i] = base + 8'(i);
    wr_count = n;
  endtask

  task automatic test_reset;
    do_reset(4, 8'h11);
    #1;
    n_total++;
    if (valid !== 1'b0 || occ !== 2'd0 || data !== 8'h00 || fifo_rd !== 1'b0)
      $display("FAIL reset_state: valid=%b occ=%0d data=%h rd=%b, required 0/0/00/0", valid, occ, data, fifo_rd);
    else n_pass++;
    $display("reset: valid=%b occ=%0d data=%h rd=%b", valid, occ, data, fifo_rd);
    tick();
  endtask

  task automatic test_stream;
    bit         exp_rd    [7] = '{1, 1, 1, 1, 0, 0, 0};
    bit         exp_valid [7] = '{0, 0, 1, 1, 1, 1, 0};
    logic [7:0] exp_data  [7] = '{8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    rst   = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      n_total++;
      if (fifo_rd !== exp_rd[c] || valid !== exp_valid[c] || (exp_valid[c] && data !== exp_data[c]))
        $display("FAIL stream_c%0d: rd=%b valid=%b data=%h, required rd=%b valid=%b data=%h",
                 c, fifo_rd, valid, data, exp_rd[c], exp_valid[c], exp_data[c]);
      else n_pass++;
      $display("stream c%0d: rd=%b empty=%b valid=%b data=%h", c, fifo_rd, fifo_empty, valid, data);
      tick();
    end
  endtask

  task automatic test_stall;
    int         reads;
    logic [7:0] exp;
    do_reset(6, 8'h11);
    rst   = 1'b0;
    reads = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (fifo_rd === 1'b1) reads++;
      if (c >= 3) begin
        n_total++;
        if (occ !== 2'd2 || data !== 8'h11 || fifo_rd !== 1'b0 || valid !== 1'b1)
          $display("FAIL stall_hold_c%0d: occ=%0d data=%h rd=%b valid=%b, required 2/11/0/1", c, occ, data, fifo_rd, valid);
        else n_pass++;
      end
      $display("stall c%0d: rd=%b occ=%0d valid=%b data=%h", c, fifo_rd, occ, valid, data);
      tick();
    end
    n_total++;
    if (reads !== 2) $display("FAIL stall_reads: got %0d reads, required 2", reads);
    else n_pass++;
    ready = 1'b1;
    #1;
    n_total++;
    if (fifo_rd !== 1'b1 || data !== 8'h11)
      $display("FAIL stall_release: rd=%b data=%h, required rd=1 data=11", fifo_rd, data);
    else n_pass++;
    tick();
    exp = 8'h12;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (valid === 1'b1) begin
        n_total++;
        if (data !== exp) $display("FAIL stall_drain: data=%h, required %h", data, exp);
        else n_pass++;
        $display("drain: data=%h", data);
        exp = exp + 8'h01;
      end
      tick();
    end
    n_total++;
    if (exp !== 8'h17) $display("FAIL stall_drain_count: next expected %h, required 17", exp);
    else n_pass++;
  endtask

  task automatic test_alternating;
    logic [7:0] exp;
    logic       prev_stall;
    logic [7:0] prev_data;
    do_reset(8, 8'h21);
    rst        = 1'b0;
    exp        = 8'h21;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int c = 0; c < 40; c++) begin
      ready = (c % 2 == 0);
      #1;
      n_total++;
      if ({1'b0, occ} + {2'b00, inflight_m} > 3'd2)
        $display("FAIL alt_invariant_c%0d: occ=%0d inflight=%b, required sum<=2", c, occ, inflight_m);
      else n_pass++;
      n_total++;
      if (fifo_rd === 1'b1 && fifo_empty === 1'b1)
        $display("FAIL alt_rd_on_empty_c%0d: rd=1 while empty, required rd=0", c);
      else n_pass++;
      if (prev_stall) begin
        n_total++;
        if (valid !== 1'b1 || data !== prev_data)
          $display("FAIL alt_hold_c%0d: valid=%b data=%h, required 1/%h", c, valid, data, prev_data);
        else n_pass++;
      end
      if (valid === 1'b1 && ready) begin
        n_total++;
        if (data !== exp) $display("FAIL alt_order_c%0d: data=%h, required %h", c, data, exp);
        else n_pass++;
        $display("alt c%0d: accepted %h", c, data);
        exp = exp + 8'h01;
      end
      prev_stall = (valid === 1'b1) && !ready;
      prev_data  = data;
      tick();
    end
    n_total++;
    if (exp !== 8'h29) $display("FAIL alt_count: next expected %h, required 29", exp);
    else n_pass++;
  endtask

  task automatic test_empty_edge;
    bit         exp_rd    [5] = '{1, 0, 0, 0, 0};
    bit         exp_valid [5] = '{0, 0, 1, 0, 0};
    do_reset(1, 8'h31);
    rst   = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++;
      if (fifo_rd !== exp_rd[c] || valid !== exp_valid[c] || (exp_valid[c] && data !== 8'h31))
        $display("FAIL empty_edge_c%0d: rd=%b valid=%b data=%h, required rd=%b valid=%b data=31",
                 c, fifo_rd, valid, data, exp_rd[c], exp_valid[c]);
      else n_pass++;
      $display("empty_edge c%0d: rd=%b empty=%b valid=%b data=%h", c, fifo_rd, fifo_empty, valid, data);
      tick();
    end
  endtask

  task automatic test_reset_midway;
    int         hold   [2] = '{3, 2};
    logic [7:0] head   [2] = '{8'h43, 8'h47};
    logic [1:0] pre_occ[2] = '{2'd2, 2'd1};
    bit         pre_inf[2] = '{0, 1};
    int         seen;
    do_reset(10, 8'h41);
    for (int p = 0; p < 2; p++) begin
      rst   = 1'b0;
      ready = 1'b0;
      for (int c = 0; c < hold[p]; c++) tick();
      #1;
      n_total++;
      if (occ !== pre_occ[p] || inflight_m !== pre_inf[p])
        $display("FAIL midrst_pre%0d: occ=%0d inflight=%b, required %0d/%b", p, occ, inflight_m, pre_occ[p], pre_inf[p]);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_total++;
      if (valid !== 1'b0 || occ !== 2'd0 || fifo_rd !== 1'b0 || data !== 8'h00)
        $display("FAIL midrst_clear%0d: valid=%b occ=%0d rd=%b data=%h, required 0/0/0/00", p, valid, occ, fifo_rd, data);
      else n_pass++;
      $display("midrst %0d: valid=%b occ=%0d rd=%b", p, valid, occ, fifo_rd);
      tick();
      rst   = 1'b0;
      ready = 1'b1;
      seen  = -1;
      for (int c = 0; c < 6 && seen < 0; c++) begin
        #1;
        if (valid === 1'b1) begin
          seen = c;
          n_total++;
          if (data !== head[p] || c != 2)
            $display("FAIL midrst_head%0d: data=%h at cycle %0d, required %h at cycle 2", p, data, c, head[p]);
          else n_pass++;
          $display("midrst %0d: first word %h at cycle %0d", p, data, c);
          rst = 1'b1;
        end
        tick();
      end
      if (seen < 0) begin
        n_total++;
        $display("FAIL midrst_timeout%0d: no valid within 6 cycles, required data %h", p, head[p]);
        rst = 1'b1;
        tick();
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b1;
    ready      = 1'b0;
    fifo_clear = 1'b1;
    wr_count   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_alternating();
    test_empty_edge();
    test_reset_midway();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
